// File: rtl/opl4_io_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// opl4_pkg
//   Shared definitions for the OPL4 I/O bus-cycle sequencer: FSM state
//   encoding, counter widths, parameter defaults and the wait-count
//   selection helper.
// ----------------------------------------------------------------------------
package opl4_pkg;

    // Sequencer states, 2-bit encoded.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned WAIT_W = 4;   // wait counter width
    localparam int unsigned IC_W   = 8;   // initial-clear counter width

    localparam int unsigned ADDR_WAIT_DEFAULT = 2;
    localparam int unsigned DATA_WAIT_DEFAULT = 6;
    localparam int unsigned IC_CYCLES_DEFAULT = 64;

    // Data-port accesses (A0=1) need the longer OPL4 recovery time.
    function automatic logic [WAIT_W-1:0] wait_load(
        input logic              a0,
        input logic [WAIT_W-1:0] addr_n,
        input logic [WAIT_W-1:0] data_n
    );
        return a0 ? data_n : addr_n;
    endfunction

endpackage : opl4_pkg

// File: rtl/opl4_io_sequencer_ic_timer.sv
// ----------------------------------------------------------------------------
// opl4_ic_timer
//   8-bit down-counter that holds the OPL4 initial-clear line low for
//   IC_CYCLES clock edges after reset release.
//
//   Ports:
//     clk_i        clock
//     rst_ni       asynchronous active-low reset (reloads the counter)
//     y_ic_o       registered active-low initial clear
//     init_done_o  high in the cycle whose closing edge releases y_ic_o and
//                  thereafter; lets the FSM leave INIT on that same edge
// ----------------------------------------------------------------------------
module opl4_ic_timer
    import opl4_pkg::*;
#(
    parameter int unsigned IC_CYCLES = IC_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic y_ic_o,
    output logic init_done_o
);

    logic [IC_W-1:0] cnt_q, cnt_d;
    logic            ic_q, ic_d;

    always_comb begin
        cnt_d = cnt_q;
        ic_d  = ic_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            // Count reaches zero on this edge: release initial clear.
            if (cnt_q == IC_W'(1)) begin
                ic_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= IC_W'(IC_CYCLES);
            ic_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ic_q  <= ic_d;
        end
    end

    assign y_ic_o      = ic_q;
    assign init_done_o = (cnt_q <= IC_W'(1));

endmodule : opl4_ic_timer

// File: rtl/opl4_io_sequencer.sv
// ----------------------------------------------------------------------------
// opl4_io_sequencer
//   Converts decoded MSX I/O reads/writes into timed OPL4 read/write strobes,
//   holds the Z80 in wait states for the OPL4 access time, and stretches the
//   OPL4 initial-clear pulse after reset.
//
//   Ports:
//     msx_CLK    MSX bus clock, all state on rising edge
//     msx_RESET  asynchronous active-low reset
//     y_CS       active-low OPL4 chip select from the decoder
//     msx_A0     port LSB (0 = register port, 1 = data port)
//     msx_RD     active-low bus read
//     msx_WR     active-low bus write
//     msx_WAIT   active-low Z80 wait request (registered)
//     y_RD       active-low OPL4 read strobe (registered)
//     y_WR       active-low OPL4 write strobe (registered)
//     y_IC       active-low OPL4 initial clear (registered)
// ----------------------------------------------------------------------------
module opl4_io_sequencer
    import opl4_pkg::*;
#(
    parameter int unsigned ADDR_WAIT = ADDR_WAIT_DEFAULT,
    parameter int unsigned DATA_WAIT = DATA_WAIT_DEFAULT,
    parameter int unsigned IC_CYCLES = IC_CYCLES_DEFAULT
) (
    input  logic msx_CLK,
    input  logic msx_RESET,
    input  logic y_CS,
    input  logic msx_A0,
    input  logic msx_RD,
    input  logic msx_WR,
    output logic msx_WAIT,
    output logic y_RD,
    output logic y_WR,
    output logic y_IC
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic              wait_q, wait_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              init_done;
    logic              req;
    logic              is_read;

    opl4_ic_timer #(
        .IC_CYCLES (IC_CYCLES)
    ) u_ic_timer (
        .clk_i       (msx_CLK),
        .rst_ni      (msx_RESET),
        .y_ic_o      (y_IC),
        .init_done_o (init_done)
    );

    assign req     = ~y_CS & (~msx_RD | ~msx_WR);
    // Read wins when both strobes are low; otherwise a request is a write.
    assign is_read = ~msx_RD;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wait_d  = wait_q;
        rd_d    = rd_q;
        wr_d    = wr_q;

        unique case (state_q)
            INIT: begin
                wait_d = 1'b1;
                rd_d   = 1'b1;
                wr_d   = 1'b1;
                if (init_done) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (req) begin
                    state_d = STROBE;
                    wcnt_d  = wait_load(msx_A0, WAIT_W'(ADDR_WAIT), WAIT_W'(DATA_WAIT));
                    wait_d  = 1'b0;
                    // Access type is captured here and held in rd_q/wr_q
                    // for the rest of the cycle.
                    rd_d    = ~is_read;
                    wr_d    = is_read;
                end
            end

            STROBE: begin
                if (!req) begin
                    // Aborted cycle: release everything on this edge.
                    state_d = IDLE;
                    wait_d  = 1'b1;
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                end else if (wcnt_q == WAIT_W'(1)) begin
                    state_d = DONE;
                    wait_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end

            DONE: begin
                // Strobe is held past the wait release so read data stays
                // valid while the Z80 latches it.
                if (!req) begin
                    state_d = IDLE;
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                end
            end

            default: begin
                state_d = INIT;
                wait_d  = 1'b1;
                rd_d    = 1'b1;
                wr_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge msx_CLK or negedge msx_RESET) begin
        if (!msx_RESET) begin
            state_q <= INIT;
            wcnt_q  <= '0;
            wait_q  <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wait_q  <= wait_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign msx_WAIT = wait_q;
    assign y_RD     = rd_q;
    assign y_WR     = wr_q;

endmodule : opl4_io_sequencer

// File: tb/tb_opl4_io_sequencer.sv
// ----------------------------------------------------------------------------
// tb_opl4_io_sequencer
//   Directed bench for opl4_io_sequencer with default parameters
//   (ADDR_WAIT=2, DATA_WAIT=6, IC_CYCLES=64). Outputs are observed packed as
//   {msx_WAIT, y_RD, y_WR, y_IC}.
// ----------------------------------------------------------------------------
module tb_opl4_io_sequencer;

    logic msx_CLK = 1'b0;
    logic msx_RESET;
    logic y_CS;
    logic msx_A0;
    logic msx_RD;
    logic msx_WR;
    logic msx_WAIT;
    logic y_RD;
    logic y_WR;
    logic y_IC;
    logic [3:0] outs;

    int tests_run = 0;
    int tests_failed = 0;

    opl4_io_sequencer dut (
        .msx_CLK   (msx_CLK),
        .msx_RESET (msx_RESET),
        .y_CS      (y_CS),
        .msx_A0    (msx_A0),
        .msx_RD    (msx_RD),
        .msx_WR    (msx_WR),
        .msx_WAIT  (msx_WAIT),
        .y_RD      (y_RD),
        .y_WR      (y_WR),
        .y_IC      (y_IC)
    );

    always #5 msx_CLK = ~msx_CLK;

    assign outs = {msx_WAIT, y_RD, y_WR, y_IC};

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge msx_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed={WAIT,RD,WR,IC}=%b expected=%b", tag, obs, exp);
        end
        $display("[TB] %s {WAIT,RD,WR,IC}=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        msx_RESET = 1'b0;
        y_CS      = 1'b1;
        msx_A0    = 1'b0;
        msx_RD    = 1'b1;
        msx_WR    = 1'b1;

        // Reset values
        step();
        step();
        check("reset", outs, 4'b1110);

        // Release reset; y_IC low for 64 edges. A write during INIT is ignored.
        msx_RESET = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            check($sformatf("init_%0d", i), outs, (i == 64) ? 4'b1111 : 4'b1110);
            if (i == 10) begin
                y_CS   = 1'b0;
                msx_WR = 1'b0;
            end
            if (i == 20) begin
                y_CS   = 1'b1;
                msx_WR = 1'b1;
            end
        end

        // Data-port write accepted on the edge right after y_IC release.
        y_CS   = 1'b0;
        msx_A0 = 1'b1;
        msx_WR = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("dwr_strobe_%0d", k), outs, 4'b0101);
        end
        step();
        check("dwr_done_1", outs, 4'b1101);
        step();
        check("dwr_done_2", outs, 4'b1101);
        msx_WR = 1'b1;
        step();
        check("dwr_release", outs, 4'b1111);
        y_CS = 1'b1;

        // Register-port read
        y_CS   = 1'b0;
        msx_A0 = 1'b0;
        msx_RD = 1'b0;
        step();
        check("rrd_strobe_1", outs, 4'b0011);
        step();
        check("rrd_strobe_2", outs, 4'b0011);
        step();
        check("rrd_done_1", outs, 4'b1011);
        step();
        check("rrd_done_2", outs, 4'b1011);
        msx_RD = 1'b1;
        y_CS   = 1'b1;
        step();
        check("rrd_release", outs, 4'b1111);

        // RD and WR both low: read only
        y_CS   = 1'b0;
        msx_A0 = 1'b0;
        msx_RD = 1'b0;
        msx_WR = 1'b0;
        step();
        check("both_strobe_1", outs, 4'b0011);
        step();
        check("both_strobe_2", outs, 4'b0011);
        step();
        check("both_done", outs, 4'b1011);
        msx_RD = 1'b1;
        msx_WR = 1'b1;
        y_CS   = 1'b1;
        step();
        check("both_release", outs, 4'b1111);

        // Aborted data write: y_CS rises after 3 strobe cycles
        y_CS   = 1'b0;
        msx_A0 = 1'b1;
        msx_WR = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("abort_strobe_%0d", k), outs, 4'b0101);
        end
        y_CS = 1'b1;
        step();
        check("abort_release", outs, 4'b1111);
        step();
        check("abort_idle", outs, 4'b1111);
        // New register write proves the FSM is back in IDLE
        y_CS   = 1'b0;
        msx_A0 = 1'b0;
        step();
        check("post_abort_strobe_1", outs, 4'b0101);
        step();
        check("post_abort_strobe_2", outs, 4'b0101);
        step();
        check("post_abort_done", outs, 4'b1101);
        msx_WR = 1'b1;
        y_CS   = 1'b1;
        step();
        check("post_abort_release", outs, 4'b1111);

        // Reset asserted mid-STROBE: outputs change asynchronously
        y_CS   = 1'b0;
        msx_A0 = 1'b1;
        msx_WR = 1'b0;
        step();
        check("rst_mid_strobe_1", outs, 4'b0101);
        step();
        check("rst_mid_strobe_2", outs, 4'b0101);
        #2;
        msx_RESET = 1'b0;
        #1;
        check("rst_async", outs, 4'b1110);
        y_CS   = 1'b1;
        msx_WR = 1'b1;
        step();
        check("rst_held", outs, 4'b1110);
        msx_RESET = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            check($sformatf("reinit_%0d", i), outs, (i == 64) ? 4'b1111 : 4'b1110);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_opl4_io_sequencer
